// File: rtl/uart_matrix_loader_pkg.sv
// Shared definitions for the UART matrix loader and its helpers.
//   - default matrix dimension, sync header and inter-byte timeout
//   - loader state encoding
//   - operand buffer select encodings
package uart_matrix_loader_pkg;

    localparam int          N_DEF              = 10;
    localparam int          DATA_W_DEF         = 8;
    localparam logic [7:0]  SYNC_BYTE_DEF      = 8'hA5;
    localparam int          TIMEOUT_CYCLES_DEF = 1_000_000;
    localparam int          ADDR_W             = 7;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        START,
        WAIT_DONE
    } state_t;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/uart_matrix_loader_rx_byte_strobe.sv
// rx_byte_strobe: turns the UART receiver's byte-ready level into a
// one-cycle byte strobe.
//   clk, rst_n  : clock, asynchronous active-low reset
//   rx_data     : byte from the receiver, stable while rx_ready is high
//   rx_ready    : byte-ready level (held for roughly one bit time)
//   byte_valid  : high for exactly one cycle on the rising edge of rx_ready
//   byte_data   : the byte belonging to that edge
// The strobe is combinational off the registered previous level so the
// consumer can register the byte in the same cycle the edge is seen.
module rx_byte_strobe #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_ready,
    output logic              byte_valid,
    output logic [DATA_W-1:0] byte_data
);

    logic rdy_p0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_p0 <= 1'b0;
        end else begin
            rdy_p0 <= rx_ready;
        end
    end

    // A level held high for many cycles produces a single strobe.
    assign byte_valid = rx_ready & ~rdy_p0;
    assign byte_data  = rx_data;

endmodule

// File: rtl/uart_matrix_loader.sv
// uart_matrix_loader: frames bytes from the UART receiver into two NxN
// operand matrices, then starts the compute pipeline and waits for it.
// Frame: SYNC_BYTE, N*N bytes of A, N*N bytes of B, all row-major.
//   clk, rst_n    : clock, asynchronous active-low reset
//   rx_data       : byte from UART receiver
//   rx_ready      : byte-ready level; each rising edge carries one byte
//   compute_done  : one-cycle completion pulse from the pipeline
//   wr_en         : operand buffer write strobe, one cycle per element
//   wr_sel        : 0 = matrix A buffer, 1 = matrix B buffer
//   wr_addr       : element index 0..N*N-1
//   wr_data       : element value
//   start         : one-cycle pipeline start pulse
//   busy          : high from start until compute_done is accepted
//   frame_done    : one-cycle pulse when compute_done is accepted
//   err_sync      : one-cycle pulse for a non-sync byte while idle
//   err_timeout   : one-cycle pulse when a frame stalls between bytes
module uart_matrix_loader
    import uart_matrix_loader_pkg::*;
#(
    parameter int                N              = N_DEF,
    parameter int                DATA_W         = DATA_W_DEF,
    parameter logic [DATA_W-1:0] SYNC_BYTE      = SYNC_BYTE_DEF,
    parameter int                TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_ready,
    input  logic              compute_done,
    output logic              wr_en,
    output logic              wr_sel,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              start,
    output logic              busy,
    output logic              frame_done,
    output logic              err_sync,
    output logic              err_timeout
);

    localparam int                TO_W     = $clog2(TIMEOUT_CYCLES);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N * N - 1);
    localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    logic              byte_valid;
    logic [DATA_W-1:0] byte_data;

    state_t            state;
    logic [ADDR_W-1:0] elem_cnt;
    logic [TO_W-1:0]   to_cnt;

    rx_byte_strobe #(
        .DATA_W(DATA_W)
    ) u_strobe (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .byte_valid(byte_valid),
        .byte_data (byte_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            elem_cnt    <= '0;
            to_cnt      <= '0;
            wr_en       <= 1'b0;
            wr_sel      <= SEL_A;
            wr_addr     <= '0;
            wr_data     <= '0;
            start       <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            err_sync    <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            // All strobes default low so each is a single-cycle pulse.
            wr_en       <= 1'b0;
            start       <= 1'b0;
            frame_done  <= 1'b0;
            err_sync    <= 1'b0;
            err_timeout <= 1'b0;

            case (state)
                IDLE: begin
                    to_cnt <= '0;
                    if (byte_valid) begin
                        if (byte_data == SYNC_BYTE) begin
                            state    <= LOAD_A;
                            elem_cnt <= '0;
                        end else begin
                            err_sync <= 1'b1;
                        end
                    end
                end

                LOAD_A, LOAD_B: begin
                    // A byte arriving on the expiry cycle takes priority
                    // over the timeout.
                    if (byte_valid) begin
                        wr_en   <= 1'b1;
                        wr_sel  <= (state == LOAD_B) ? SEL_B : SEL_A;
                        wr_addr <= elem_cnt;
                        wr_data <= byte_data;
                        to_cnt  <= '0;
                        if (elem_cnt == LAST_IDX) begin
                            elem_cnt <= '0;
                            state    <= (state == LOAD_A) ? LOAD_B : START;
                        end else begin
                            elem_cnt <= elem_cnt + ADDR_W'(1);
                        end
                    end else if (to_cnt == TO_LAST) begin
                        // Already-written elements are left in the buffers.
                        err_timeout <= 1'b1;
                        state       <= IDLE;
                        elem_cnt    <= '0;
                        to_cnt      <= '0;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end

                // One cycle after the final B write, so start never
                // coincides with wr_en.
                START: begin
                    start <= 1'b1;
                    busy  <= 1'b1;
                    state <= WAIT_DONE;
                end

                // Incoming bytes are dropped silently while computing.
                WAIT_DONE: begin
                    if (compute_done) begin
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                        state      <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_matrix_loader.sv
// Bench for uart_matrix_loader: directed phases with randomized bytes and
// gaps; a monitor logs every observed write/pulse and the expected
// results are built from the frame contents the bench sent.
module tb_uart_matrix_loader;

    localparam int TC = 200;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_ready = 1'b0;
    logic       compute_done = 1'b0;
    logic       wr_en, wr_sel, start, busy, frame_done, err_sync, err_timeout;
    logic [6:0] wr_addr;
    logic [7:0] wr_data;

    uart_matrix_loader #(
        .N(10), .DATA_W(8), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_ready(rx_ready),
        .compute_done(compute_done), .wr_en(wr_en), .wr_sel(wr_sel),
        .wr_addr(wr_addr), .wr_data(wr_data), .start(start), .busy(busy),
        .frame_done(frame_done), .err_sync(err_sync), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: log of everything the DUT emits.
    logic [15:0] wq[$];
    int          wcyc[$];
    int n_start = 0, n_fd = 0, n_esync = 0, n_eto = 0, n_excl = 0, start_cyc = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_en) begin
                wq.push_back({wr_sel, wr_addr, wr_data});
                wcyc.push_back(cyc);
            end
            if (start) begin
                n_start++;
                start_cyc = cyc;
            end
            if (frame_done) n_fd++;
            if (err_sync) n_esync++;
            if (err_timeout) n_eto++;
            if ((wr_en && start) || (err_sync && err_timeout)) n_excl++;
        end
    end

    int checks = 0, errors = 0;
    int last_acc = 0;
    logic [7:0] fa[100];
    logic [7:0] fb[100];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Raises rx_ready at a falling edge; the byte is accepted at the next
    // rising edge, whose index is recorded in last_acc.
    task automatic send_byte(input logic [7:0] b);
        int hold = $urandom_range(1, 4);
        int gap  = $urandom_range(1, 3);
        @(negedge clk);
        rx_data  = b;
        rx_ready = 1'b1;
        last_acc = cyc + 1;
        repeat (hold) @(negedge clk);
        rx_ready = 1'b0;
        repeat (gap - 1) @(negedge clk);
    endtask

    task automatic run_frame(input string tag);
        int base = wq.size();
        int s0 = n_start;
        logic [15:0] exp;
        send_byte(8'hA5);
        for (int k = 0; k < 100; k++) send_byte(fa[k]);
        for (int k = 0; k < 100; k++) send_byte(fb[k]);
        repeat (3) @(negedge clk);
        #1;
        chk({tag, "_nwrites"}, wq.size() - base, 200);
        if (wq.size() >= base + 200) begin
            for (int k = 0; k < 200; k++) begin
                exp = (k < 100) ? {1'b0, 7'(k), fa[k]} : {1'b1, 7'(k - 100), fb[k - 100]};
                chk($sformatf("%s_wr%0d", tag, k), wq[base + k], exp);
            end
            chk({tag, "_lastwr_cyc"}, wcyc[base + 199], last_acc);
        end
        chk({tag, "_nstart"}, n_start - s0, 1);
        chk({tag, "_start_cyc"}, start_cyc, last_acc + 1);
        chk({tag, "_busy"}, busy, 1);
    endtask

    task automatic finish_compute(input string tag);
        int f0 = n_fd;
        while (cyc < start_cyc + 50) @(negedge clk);
        compute_done = 1'b1;
        @(negedge clk);
        compute_done = 1'b0;
        @(negedge clk);
        #1;
        chk({tag, "_frame_done"}, n_fd - f0, 1);
        chk({tag, "_busy_clr"}, busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int b0, e0, s0, t0, f0, target;
        logic [7:0] x;

        // Reset state.
        repeat (3) @(negedge clk);
        #1;
        chk("rst_outs", {wr_en, wr_sel, wr_addr, wr_data, start, busy, frame_done,
                         err_sync, err_timeout}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // compute_done while idle is ignored.
        f0 = n_fd;
        @(negedge clk);
        compute_done = 1'b1;
        @(negedge clk);
        compute_done = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_done_ignored", n_fd - f0, 0);

        // Frame 1: ramp data.
        for (int k = 0; k < 100; k++) begin
            fa[k] = 8'(k);
            fb[k] = 8'(k + 100);
        end
        run_frame("f1");
        finish_compute("f1");

        // Bad header in idle.
        b0 = wq.size(); e0 = n_esync;
        send_byte(8'h3C);
        repeat (3) @(negedge clk);
        chk("esync_pulse", n_esync - e0, 1);
        chk("esync_nowr", wq.size() - b0, 0);

        // Frame 2: random data including sync-valued elements.
        for (int k = 0; k < 100; k++) begin
            fa[k] = 8'($urandom);
            fb[k] = 8'($urandom);
        end
        fa[5] = 8'hA5;
        fb[0] = 8'hA5;
        run_frame("f2");

        // Bytes during compute are dropped.
        b0 = wq.size(); e0 = n_esync; t0 = n_eto;
        send_byte(8'hA5);
        for (int k = 0; k < 4; k++) send_byte(8'($urandom));
        repeat (2) @(negedge clk);
        chk("wait_nowr", wq.size() - b0, 0);
        chk("wait_noerr", (n_esync - e0) + (n_eto - t0), 0);
        chk("wait_busy", busy, 1);
        finish_compute("f2");

        // Timeout after 37 A bytes.
        b0 = wq.size(); t0 = n_eto;
        send_byte(8'hA5);
        for (int k = 0; k < 37; k++) send_byte(8'($urandom));
        repeat (TC + 20) @(negedge clk);
        chk("to_nwr", wq.size() - b0, 37);
        chk("to_pulse", n_eto - t0, 1);
        chk("to_idle_quiet", wq.size() - b0, 37);
        x = 8'($urandom);
        send_byte(8'hA5);
        send_byte(x);
        repeat (2) @(negedge clk);
        chk("to_restart_wr", wq[wq.size() - 1], {1'b0, 7'd0, x});

        // Level held high: exactly one byte, then the frame times out.
        b0 = wq.size(); t0 = n_eto;
        @(negedge clk);
        rx_data  = 8'h11;
        rx_ready = 1'b1;
        repeat (10000) @(negedge clk);
        rx_ready = 1'b0;
        @(negedge clk);
        chk("hold_one_wr", wq.size() - b0, 1);
        chk("hold_wr_val", wq[wq.size() - 1], {1'b0, 7'd1, 8'h11});
        chk("hold_timeout", n_eto - t0, 1);

        // Byte exactly on the expiry cycle wins over the timeout.
        b0 = wq.size(); t0 = n_eto;
        send_byte(8'hA5);
        send_byte(8'h42);
        target = last_acc + TC;
        while (cyc + 1 < target) @(negedge clk);
        rx_data  = 8'h77;
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("exp_nwr", wq.size() - b0, 2);
        chk("exp_wr_val", wq[wq.size() - 1], {1'b0, 7'd1, 8'h77});
        chk("exp_no_to", n_eto - t0, 0);

        // One cycle later is too late: timeout, then the byte hits idle.
        b0 = wq.size(); e0 = n_esync;
        target = cyc + 1 - 1 + TC + 1;
        target = (target < 0) ? 0 : target;
        target = wcyc[wcyc.size() - 1] + TC + 1;
        while (cyc + 1 < target) @(negedge clk);
        rx_data  = 8'h5A;
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("late_to", n_eto - t0, 1);
        chk("late_esync", n_esync - e0, 1);
        chk("late_nowr", wq.size() - b0, 0);

        // Reset mid LOAD_B while a write strobe is up.
        send_byte(8'hA5);
        for (int k = 0; k < 102; k++) send_byte(8'($urandom));
        @(negedge clk);
        rx_data  = 8'hC3;
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        chk("pre_rst_wr", {wr_en, wr_sel, wr_addr, wr_data}, {1'b1, 1'b1, 7'd2, 8'hC3});
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_outs", {wr_en, wr_sel, wr_addr, wr_data, start, busy, frame_done,
                               err_sync, err_timeout}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        e0 = n_esync; b0 = wq.size();
        send_byte(8'h3C);
        repeat (2) @(negedge clk);
        chk("post_rst_idle", n_esync - e0, 1);
        chk("post_rst_nowr", wq.size() - b0, 0);

        // Reset mid compute clears busy.
        for (int k = 0; k < 100; k++) begin
            fa[k] = 8'($urandom);
            fb[k] = 8'($urandom);
        end
        run_frame("f3");
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_busy", {busy, start}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        s0 = n_start;
        repeat (5) @(negedge clk);
        chk("rst_no_start", n_start - s0, 0);

        chk("exclusive_pulses", n_excl, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
